// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the cpu_step_ctrl run/step sequencer.
// Holds the 2-bit state encoding seen on o_state_out and the default debounce length.
package cpu_step_ctrl_pkg;

  localparam int unsigned STATE_W            = 2;
  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;

  typedef enum logic [STATE_W-1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_step_ctrl_btn.sv
// btn_debounce: two-flop synchroniser, stable-level debouncer and rising-edge detector
// for one raw push button.
// Ports:
//   i_clk    board clock
//   i_rst    synchronous active-high reset
//   i_btn    raw, asynchronous button level
//   o_press  one-cycle pulse when the debounced level rises
module btn_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  // Counter only needs to reach DEB_CYCLES-1.
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Counter measures how long the synchronised input has disagreed with the accepted
  // level; any agreeing sample restarts it, so only a clean run of DEB_CYCLES flips it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/step/halt sequencer producing a one-cycle processor clock enable
// in the board clock domain, plus display latch and executed-cycle counter.
// Optional breakpoint support is compiled in with macro CPU_STEP_BREAKPOINT_EN.
// Ports:
//   i_clk, i_rst          board clock, synchronous active-high reset
//   i_btn_run, i_btn_step raw buttons (toggle run/pause, single step)
//   i_halt_req            level, forces HALT while high
//   i_result_in           processor ResultW
//   i_bp_addr, i_mem_addr, i_mem_write   breakpoint inputs (macro builds only)
//   o_cpu_en              one-cycle enable pulse to the processor
//   o_disp_value          result_in[15:0] captured on each pulse
//   o_cycle_count         number of pulses issued (wraps)
//   o_state_out           PAUSE=0 RUN=1 STEP=2 HALT=3
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned RATE_W     = 26,
  parameter int unsigned RATE_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_btn_run,
  input  logic               i_btn_step,
  input  logic               i_halt_req,
  input  logic [31:0]        i_result_in,
`ifdef CPU_STEP_BREAKPOINT_EN
  input  logic [31:0]        i_bp_addr,
  input  logic [31:0]        i_mem_addr,
  input  logic               i_mem_write,
`endif
  output logic               o_cpu_en,
  output logic [15:0]        o_disp_value,
  output logic [CNT_W-1:0]   o_cycle_count,
  output logic [STATE_W-1:0] o_state_out
);

  localparam logic [RATE_W-1:0] DIV_MAX = RATE_W'(RATE_DIV - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [RATE_W-1:0] r_div;
  logic [RATE_W-1:0] w_div_next;
  logic              r_cpu_en;
  logic              w_pulse;
  logic [15:0]       r_disp;
  logic [CNT_W-1:0]  r_count;
  logic              w_run_press;
  logic              w_step_press;
  logic              w_bp_hit;
  logic              w_halt;
  logic              w_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_run),
    .o_press (w_run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_step),
    .o_press (w_step_press)
  );

  // Breakpoint is judged only on the cycle the processor actually executes.
`ifdef CPU_STEP_BREAKPOINT_EN
  assign w_bp_hit = r_cpu_en & i_mem_write & (i_mem_addr == i_bp_addr);
`else
  assign w_bp_hit = 1'b0;
`endif

  assign w_halt   = i_halt_req | w_bp_hit;
  assign w_unused = ^i_result_in[31:16];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_PAUSE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; halt outranks every button event, run outranks step.
  always_comb begin
    w_state_next = r_state;
    if (w_halt) begin
      w_state_next = ST_HALT;
    end else begin
      case (r_state)
        ST_PAUSE: begin
          if (w_run_press)       w_state_next = ST_RUN;
          else if (w_step_press) w_state_next = ST_STEP;
        end
        ST_RUN:  if (w_run_press) w_state_next = ST_PAUSE;
        ST_STEP: w_state_next = ST_PAUSE;
        ST_HALT: if (w_run_press) w_state_next = ST_PAUSE;
        default: w_state_next = ST_PAUSE;
      endcase
    end
  end

  // Output logic: pulse request and divider next value. The divider rests at zero
  // outside RUN so entering RUN always starts a full period.
  always_comb begin
    w_pulse    = 1'b0;
    w_div_next = '0;
    case (r_state)
      ST_RUN: begin
        if (w_state_next == ST_RUN) begin
          if (r_div == DIV_MAX) begin
            w_pulse    = 1'b1;
            w_div_next = '0;
          end else begin
            w_div_next = r_div + RATE_W'(1);
          end
        end
      end
      ST_STEP: w_pulse = ~w_halt;
      default: ;
    endcase
  end

  // Registered enable, divider, display latch and executed-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div    <= '0;
      r_cpu_en <= 1'b0;
      r_disp   <= '0;
      r_count  <= '0;
    end else begin
      r_div    <= w_div_next;
      r_cpu_en <= w_pulse;
      if (r_cpu_en) begin
        r_disp  <= i_result_in[15:0];
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_cpu_en      = r_cpu_en;
  assign o_disp_value  = r_disp;
  assign o_cycle_count = r_count;
  assign o_state_out   = r_state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl (DEB_CYCLES=4, RATE_DIV=5).
module tb_cpu_step_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_run;
  logic        btn_step;
  logic        halt_req;
  logic [31:0] result_in;
  logic        cpu_en;
  logic [15:0] disp_value;
  logic [31:0] cycle_count;
  logic [1:0]  state_out;
`ifdef CPU_STEP_BREAKPOINT_EN
  logic [31:0] bp_addr;
  logic [31:0] mem_addr;
  logic        mem_write;
`endif

  int tests = 0;
  int fails = 0;

  cpu_step_ctrl #(
    .RATE_W     (26),
    .RATE_DIV   (5),
    .DEB_CYCLES (4),
    .CNT_W      (32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_run     (btn_run),
    .i_btn_step    (btn_step),
    .i_halt_req    (halt_req),
    .i_result_in   (result_in),
`ifdef CPU_STEP_BREAKPOINT_EN
    .i_bp_addr     (bp_addr),
    .i_mem_addr    (mem_addr),
    .i_mem_write   (mem_write),
`endif
    .o_cpu_en      (cpu_en),
    .o_disp_value  (disp_value),
    .o_cycle_count (cycle_count),
    .o_state_out   (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: sees the pre-edge value of cpu_en at each rising edge.
  int unsigned cyc      = 0;
  int unsigned n_pulse  = 0;
  int unsigned n_double = 0;
  int          pulse_t[$];
  logic        prev_en  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (cpu_en === 1'b1) begin
      n_pulse++;
      pulse_t.push_back(int'(cyc));
      if (prev_en === 1'b1) n_double++;
    end
    prev_en = cpu_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
    int n = 0;
    while (state_out !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(state_out), 64'(exp));
  endtask

  task automatic press_step(input int hold);
    btn_step = 1'b1;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int unsigned n0;
    int          gaps_bad;
    int          sz;
    logic [1:0]  exp_bp_state;

    rst       = 1'b1;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    halt_req  = 1'b0;
    result_in = 32'h0;
`ifdef CPU_STEP_BREAKPOINT_EN
    bp_addr   = 32'h0;
    mem_addr  = 32'h0;
    mem_write = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, then idle.
    chk("rst_state", 64'(state_out), 64'd0);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    chk("rst_disp", 64'(disp_value), 64'd0);
    n0 = n_pulse;
    repeat (50) @(negedge clk);
    chk("idle_pulses", 64'(n_pulse - n0), 64'd0);
    chk("idle_state", 64'(state_out), 64'd0);
    chk("idle_count", 64'(cycle_count), 64'd0);

    // Single step.
    result_in = 32'h0000ABCD;
    n0 = n_pulse;
    press_step(10);
    chk("step_pulses", 64'(n_pulse - n0), 64'd1);
    chk("step_disp", 64'(disp_value), 64'hABCD);
    chk("step_count", 64'(cycle_count), 64'd1);
    chk("step_state", 64'(state_out), 64'd0);

    // Free run: 52 clocks from RUN entry hold exactly 10 pulses spaced 5 apart.
    btn_run = 1'b1;
    wait_state("run_enter", 2'd1, 40);
    btn_run = 1'b0;
    n0 = n_pulse;
    repeat (52) @(negedge clk);
    chk("run_pulses", 64'(n_pulse - n0), 64'd10);
    gaps_bad = 0;
    sz = pulse_t.size();
    for (int i = sz - 9; i < sz; i++) begin
      if (i < 1 || (pulse_t[i] - pulse_t[i-1]) != 5) gaps_bad++;
    end
    chk("run_gaps", 64'(gaps_bad), 64'd0);
    chk("run_count", 64'(cycle_count), 64'd11);
    chk("run_disp", 64'(disp_value), 64'hABCD);

    // Second run press pauses.
    btn_run = 1'b1;
    wait_state("run_pause", 2'd0, 40);
    repeat (2) @(negedge clk);
    btn_run = 1'b0;
    n0 = n_pulse;
    repeat (20) @(negedge clk);
    chk("pause_pulses", 64'(n_pulse - n0), 64'd0);
    chk("pause_state", 64'(state_out), 64'd0);

    // Halt from RUN; step cannot leave HALT, run can.
    btn_run = 1'b1;
    wait_state("halt_run_enter", 2'd1, 40);
    btn_run = 1'b0;
    repeat (3) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    chk("halt_enter", 64'(state_out), 64'd3);
    repeat (2) @(negedge clk);
    n0 = n_pulse;
    repeat (17) @(negedge clk);
    chk("halt_pulses", 64'(n_pulse - n0), 64'd0);
    chk("halt_hold", 64'(state_out), 64'd3);
    halt_req = 1'b0;
    n0 = n_pulse;
    press_step(8);
    chk("halt_step_state", 64'(state_out), 64'd3);
    chk("halt_step_pulses", 64'(n_pulse - n0), 64'd0);
    btn_run = 1'b1;
    wait_state("halt_exit", 2'd0, 40);
    btn_run = 1'b0;
    repeat (10) @(negedge clk);

    // Simultaneous presses from PAUSE: run wins.
    btn_run  = 1'b1;
    btn_step = 1'b1;
    for (int n = 0; n < 40 && state_out === 2'd0; n++) @(negedge clk);
    chk("both_run_wins", 64'(state_out), 64'd1);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    btn_run = 1'b1;
    wait_state("both_pause", 2'd0, 40);
    btn_run = 1'b0;
    repeat (10) @(negedge clk);

    // Bouncy step press gives exactly one step.
    result_in = 32'h00001234;
    n0 = n_pulse;
    for (int i = 0; i < 6; i++) begin
      btn_step = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    press_step(10);
    chk("bounce_pulses", 64'(n_pulse - n0), 64'd1);
    chk("bounce_disp", 64'(disp_value), 64'h1234);
    chk("bounce_state", 64'(state_out), 64'd0);

    // Reset in the cycle before a due RUN pulse.
    btn_run = 1'b1;
    wait_state("rst_run_enter", 2'd1, 40);
    btn_run = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cpu_en", 64'(cpu_en), 64'd0);
    chk("midrst_state", 64'(state_out), 64'd0);
    chk("midrst_count", 64'(cycle_count), 64'd0);
    chk("midrst_disp", 64'(disp_value), 64'd0);
    rst = 1'b0;
    n0 = n_pulse;
    repeat (10) @(negedge clk);
    chk("midrst_pulses", 64'(n_pulse - n0), 64'd0);

    // Step with a store to the breakpoint address (halts only in macro builds).
    result_in = 32'h00005A5A;
`ifdef CPU_STEP_BREAKPOINT_EN
    bp_addr      = 32'h40;
    mem_addr     = 32'h40;
    mem_write    = 1'b1;
    exp_bp_state = 2'd3;
`else
    exp_bp_state = 2'd0;
`endif
    n0 = n_pulse;
    press_step(10);
    chk("bp_pulses", 64'(n_pulse - n0), 64'd1);
    chk("bp_count", 64'(cycle_count), 64'd1);
    chk("bp_disp", 64'(disp_value), 64'h5A5A);
    chk("bp_state", 64'(state_out), 64'(exp_bp_state));
`ifdef CPU_STEP_BREAKPOINT_EN
    mem_write = 1'b0;
    btn_run   = 1'b1;
    wait_state("bp_exit", 2'd0, 40);
    btn_run   = 1'b0;
    repeat (10) @(negedge clk);
`endif

    chk("no_double_pulse", 64'(n_double), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
